trng_word_gen: RTL and testbench

Parametrised successor to the 8-RO single-bit TRNG top. It instantiates NUM_RO ring oscillators with distinct delays, XOR-combines them, synchronises and samples the result, and runs on-line health tests on the raw samples. The samples are then von Neumann debiased and packed into WORD_W-bit words delivered over a valid/ready handshake. It sits between the entropy source and any consumer bus/DRBG seeding logic.

---
 rtl/trng_word_gen.sv | 187 ++++++++++++++++++
 tb/tb_trng_word_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/trng_word_gen.sv
// Multi-RO entropy source with repetition-count / adaptive-proportion health tests,
// von Neumann debiasing and valid/ready word packing. Optional APT: `define TRNG_APT_EN.
module trng_word_gen #(
    parameter int NUM_RO     = 8,
    parameter int WORD_W     = 32,
    parameter int RCT_CUTOFF = 8,
    parameter int APT_WINDOW = 64,
    parameter int APT_CUTOFF = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              test_mode,
    input  logic              test_bit,
    input  logic              word_ready,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              health_fail,
    output logic [1:0]        fail_code
);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int RCT_W = $clog2(RCT_CUTOFF + 1);

    logic [NUM_RO-1:0] ro_out;

    // Behavioural oscillator model: instance gi toggles every gi+1 clocks. Swap in the
    // placed inverter-ring primitive for silicon; everything downstream is unchanged.
    generate
        for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro
            logic [4:0] phase_reg;
            logic       osc_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    phase_reg <= '0;
                    osc_reg   <= 1'b0;
                end else if (phase_reg == 5'(gi)) begin
                    phase_reg <= '0;
                    osc_reg   <= ~osc_reg;
                end else begin
                    phase_reg <= phase_reg + 5'd1;
                end
            end
            assign ro_out[gi] = osc_reg;
        end
    endgenerate

    logic src;
    logic s1_reg, s2_reg, en_d1_reg, sv_reg;

    assign src = test_mode ? test_bit : ^ro_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            en_d1_reg <= 1'b0;
            sv_reg    <= 1'b0;
        end else begin
            s1_reg    <= src;
            s2_reg    <= s1_reg;
            en_d1_reg <= enable;
            sv_reg    <= en_d1_reg;
        end
    end

    // Repetition-count test
    logic [RCT_W-1:0] rct_len_reg, rct_len_next;
    logic             rct_last_reg;
    logic             rct_hit;

    always_comb begin
        rct_len_next = rct_len_reg;
        if (rct_len_reg == '0 || s2_reg != rct_last_reg)
            rct_len_next = RCT_W'(1);
        else if (rct_len_reg != RCT_W'(RCT_CUTOFF))
            rct_len_next = rct_len_reg + RCT_W'(1);
        rct_hit = sv_reg && (rct_len_next == RCT_W'(RCT_CUTOFF));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_len_reg  <= '0;
            rct_last_reg <= 1'b0;
        end else if (sv_reg) begin
            rct_len_reg  <= rct_len_next;
            rct_last_reg <= s2_reg;
        end
    end

    logic apt_hit;

`ifdef TRNG_APT_EN
    localparam int APT_W = $clog2(APT_WINDOW + 1);
    logic [APT_W-1:0] apt_win_reg, apt_cnt_reg, apt_cnt_next;
    logic             apt_ref_reg;

    always_comb begin
        apt_cnt_next = apt_cnt_reg;
        if (apt_win_reg == '0)
            apt_cnt_next = APT_W'(1);
        else if (s2_reg == apt_ref_reg)
            apt_cnt_next = apt_cnt_reg + APT_W'(1);
        apt_hit = sv_reg && (apt_cnt_next == APT_W'(APT_CUTOFF));
    end

    // apt_win_reg == 0 means "next valid sample opens a window"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apt_win_reg <= '0;
            apt_cnt_reg <= '0;
            apt_ref_reg <= 1'b0;
        end else if (sv_reg) begin
            apt_cnt_reg <= apt_cnt_next;
            if (apt_win_reg == '0) begin
                apt_ref_reg <= s2_reg;
                apt_win_reg <= APT_W'(1);
            end else if (apt_win_reg == APT_W'(APT_WINDOW - 1)) begin
                apt_win_reg <= '0;
            end else begin
                apt_win_reg <= apt_win_reg + APT_W'(1);
            end
        end
    end
`else
    // Window parameters only matter when the APT is built in.
    assign apt_hit = 1'b0 & (APT_CUTOFF <= APT_WINDOW);
`endif

    // Von Neumann pairing and word packing
    logic                pair_full_reg, pair_a_reg;
    logic [WORD_W-1:0]   shift_reg, word_next;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic                vn_emit, word_done;
    logic [1:0]          fail_next;

    assign vn_emit   = sv_reg && pair_full_reg && (pair_a_reg != s2_reg);
    assign word_done = vn_emit && (bit_cnt_reg == BIT_W'(WORD_W - 1));
    assign word_next = {pair_a_reg, shift_reg[WORD_W-1:1]};
    assign fail_next = fail_code | {apt_hit, rct_hit};
    assign health_fail = |fail_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_code     <= 2'b00;
            word_out      <= '0;
            word_valid    <= 1'b0;
            pair_full_reg <= 1'b0;
            pair_a_reg    <= 1'b0;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
        end else begin
            fail_code <= fail_next;
            if (|fail_next) begin
                word_valid    <= 1'b0;
                word_out      <= '0;
                pair_full_reg <= 1'b0;
                shift_reg     <= '0;
                bit_cnt_reg   <= '0;
            end else begin
                if (word_valid && word_ready)
                    word_valid <= 1'b0;
                if (!sv_reg) begin
                    pair_full_reg <= 1'b0;
                    shift_reg     <= '0;
                    bit_cnt_reg   <= '0;
                end else if (!pair_full_reg) begin
                    pair_full_reg <= 1'b1;
                    pair_a_reg    <= s2_reg;
                end else begin
                    pair_full_reg <= 1'b0;
                    if (word_done) begin
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                        // A word still waiting on the consumer wins; the new one is dropped.
                        if (!word_valid || word_ready) begin
                            word_out   <= word_next;
                            word_valid <= 1'b1;
                        end
                    end else if (vn_emit) begin
                        shift_reg   <= word_next;
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_trng_word_gen.sv
// Directed bench for trng_word_gen (WORD_W=8, test_mode path); APT expectations follow TRNG_APT_EN.
module tb_trng_word_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       test_mode = 1'b1;
    logic       test_bit = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_out;
    logic       word_valid;
    logic       health_fail;
    logic [1:0] fail_code;

    int checks = 0;
    int errors = 0;

    int         vc, fi, li, fx;
    logic [7:0] fw, lw;

    trng_word_gen #(.WORD_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .test_mode(test_mode), .test_bit(test_bit),
        .word_ready(word_ready), .word_out(word_out), .word_valid(word_valid),
        .health_fail(health_fail), .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; word_ready = 1'b0; test_bit = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Step i drives sample bits[i] before edge i and observes just after edge i.
    task automatic run_seq(input logic [63:0] bits, input int n, input int extra, input int ready_from,
                           output int valid_cnt, output int first_idx, output int last_idx,
                           output logic [7:0] first_word, output logic [7:0] last_word,
                           output int fail_idx);
        logic       prev_v = 1'b0;
        logic [7:0] prev_w = 8'h00;
        valid_cnt = 0; first_idx = -1; last_idx = -1; fail_idx = -1;
        first_word = 8'h00; last_word = 8'h00;
        for (int i = 0; i < n + extra; i++) begin
            enable     = (i < n);
            test_bit   = (i < n) ? bits[i] : 1'b0;
            word_ready = (i >= ready_from);
            @(posedge clk); #1;
            if (word_valid) begin
                valid_cnt++;
                if (first_idx < 0) begin first_idx = i; first_word = word_out; end
                last_idx = i; last_word = word_out;
                if (!prev_v || word_out != prev_w)
                    $display("  word 0x%02h presented at step %0d", word_out, i);
            end
            if (fail_idx < 0 && fail_code != 2'b00) fail_idx = i;
            prev_v = word_valid; prev_w = word_out;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL reset_word_out: got %0h expected 0", word_out); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %0b expected 0", word_valid); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health_fail: got %0b expected 0", health_fail); end
        checks++; if (fail_code !== 2'b00) begin errors++; $display("FAIL reset_fail_code: got %0b expected 00", fail_code); end
        rst = 1'b0;
    endtask

    task automatic test_alt_ones();
        do_reset();
        run_seq(64'h5555, 16, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (fw !== 8'hFF) begin errors++; $display("FAIL alt10_word: got %02h expected ff", fw); end
        checks++; if (fi != 17) begin errors++; $display("FAIL alt10_latency: got step %0d expected 17", fi); end
        checks++; if (vc != 1) begin errors++; $display("FAIL alt10_valid_cycles: got %0d expected 1", vc); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL alt10_health: got %0b expected 0", health_fail); end
    endtask

    task automatic test_mixed_pairs();
        do_reset();
        run_seq(64'h6666, 16, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (fw !== 8'hAA) begin errors++; $display("FAIL mixed_word: got %02h expected aa", fw); end
        checks++; if (fi != 17) begin errors++; $display("FAIL mixed_latency: got step %0d expected 17", fi); end
    endtask

    task automatic test_rct();
        do_reset();
        run_seq(64'hFFF, 12, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (fx != 9) begin errors++; $display("FAIL rct_fire_step: got %0d expected 9", fx); end
        checks++; if (fail_code !== 2'b01) begin errors++; $display("FAIL rct_code: got %0b expected 01", fail_code); end
        run_seq(64'h5555, 16, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (vc != 0) begin errors++; $display("FAIL rct_blocks_words: got %0d valid cycles expected 0", vc); end
        checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL rct_sticky: got %0b expected 1", health_fail); end
    endtask

    task automatic test_apt();
        do_reset();
        run_seq(64'h0777_7777_7777_7777, 60, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (fw !== 8'hFF || fi != 33) begin errors++; $display("FAIL apt_word: got %02h at step %0d expected ff at 33", fw, fi); end
`ifdef TRNG_APT_EN
        checks++; if (fx != 54) begin errors++; $display("FAIL apt_fire_step: got %0d expected 54", fx); end
        checks++; if (fail_code !== 2'b10) begin errors++; $display("FAIL apt_code: got %0b expected 10", fail_code); end
`else
        checks++; if (fx != -1) begin errors++; $display("FAIL apt_absent_step: got %0d expected -1", fx); end
        checks++; if (fail_code !== 2'b00) begin errors++; $display("FAIL apt_absent_code: got %0b expected 00", fail_code); end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        run_seq(64'h6666_5555, 32, 4, 1000, vc, fi, li, fw, lw, fx);
        checks++; if (fi != 17 || fw !== 8'hFF) begin errors++; $display("FAIL bp_first: got %02h at step %0d expected ff at 17", fw, fi); end
        checks++; if (lw !== 8'hFF) begin errors++; $display("FAIL bp_held_word: got %02h expected ff", lw); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid: got %0b expected 1", word_valid); end
        word_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_after_transfer: got %0b expected 0", word_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_seq(64'h6666_5555, 32, 4, 33, vc, fi, li, fw, lw, fx);
        checks++; if (lw !== 8'hAA) begin errors++; $display("FAIL b2b_second_word: got %02h expected aa", lw); end
        checks++; if (li != 33) begin errors++; $display("FAIL b2b_last_valid: got step %0d expected 33", li); end
        checks++; if (vc != 17) begin errors++; $display("FAIL b2b_valid_cycles: got %0d expected 17", vc); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        run_seq(64'h155, 10, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (vc != 0) begin errors++; $display("FAIL en_partial_valid: got %0d expected 0", vc); end
        run_seq(64'h6666, 16, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (fw !== 8'hAA || fi != 17) begin errors++; $display("FAIL en_fresh_word: got %02h at step %0d expected aa at 17", fw, fi); end
        checks++; if (vc != 1) begin errors++; $display("FAIL en_fresh_count: got %0d expected 1", vc); end
    endtask

    task automatic test_rst_mid_word();
        do_reset();
        run_seq(64'h155_5555, 26, 0, 1000, vc, fi, li, fw, lw, fx);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL rst_pending_before: got %0b expected 1", word_valid); end
        #2 rst = 1'b1; enable = 1'b0;
        #1;
        checks++; if (word_out !== 8'h00) begin errors++; $display("FAIL rst_async_word: got %02h expected 00", word_out); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b expected 0", word_valid); end
        checks++; if (fail_code !== 2'b00 || health_fail !== 1'b0) begin errors++; $display("FAIL rst_async_health: got %0b/%0b expected 00/0", fail_code, health_fail); end
        @(posedge clk); #1;
        rst = 1'b0;
        run_seq(64'h6666, 16, 4, 0, vc, fi, li, fw, lw, fx);
        checks++; if (fw !== 8'hAA || fi != 17) begin errors++; $display("FAIL rst_fresh_word: got %02h at step %0d expected aa at 17", fw, fi); end
        checks++; if (vc != 1) begin errors++; $display("FAIL rst_fresh_count: got %0d expected 1", vc); end
    endtask

    initial begin
        test_reset();
        test_alt_ones();
        test_mixed_pairs();
        test_rct();
        test_apt();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_rst_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
